// File: rtl/subtract_lookahead_pipe_16_bit.sv
// -----------------------------------------------------------------------------
// subtract_lookahead_pipe_16_bit
//
// Purpose:
//   Two-stage pipelined subtract/compare unit for the GSU ALU (SUB, SBC, CMP).
//   Computes a + ~b + cin (cin = in_sbc ? in_cy : 1), i.e. a - b - borrow.
//   Stage 1 produces the low half with 4-bit lookahead groups, and registers
//   the low-half carry-out. Stage 2 produces the high half from that
//   registered carry, then derives the Z/S/CY/OV flags.
//
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready depends on out_ready)
//   in_a, in_b            minuend / subtrahend
//   in_sbc, in_cy         SBC select and current CY flag (1 = no borrow)
//   in_tag                opaque destination tag, passed through unchanged
//   out_valid / out_ready result handshake
//   out_result            a - b - borrow modulo 2^WIDTH
//   out_z, out_s          zero / sign of the result
//   out_cy                1 = no borrow out
//   out_ov                signed overflow
//   out_tag               tag of this result
// -----------------------------------------------------------------------------

// Half-width adder for a + nb + cin built from 4-bit lookahead groups. Inside
// a group, every carry is derived from the group carry-in through prefix
// generate/propagate terms. Group carries ripple from group to group. The
// last group is narrower when HW is not a multiple of 4.
module sub_la_half #(
  parameter int HW = 8
) (
  input  logic [HW-1:0] i_a,
  input  logic [HW-1:0] i_nb,
  input  logic          i_cin,
  output logic [HW-1:0] o_sum,
  output logic          o_cout
);
  localparam int NG = (HW + 3) / 4;

  logic [HW-1:0] w_p;
  logic [HW-1:0] w_g;

  assign w_p = i_a ^ i_nb;
  assign w_g = i_a & i_nb;

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      localparam int LO = gi * 4;
      localparam int GW = ((HW - LO) < 4) ? (HW - LO) : 4;

      logic          w_cin_g;
      logic          w_cout_g;
      logic [GW-1:0] w_sum_g;
      // Prefix generate/propagate from the group's LSB up to bit j (exclusive).
      logic [GW:0]   w_gg;
      logic [GW:0]   w_gp;

      if (gi == 0) begin : g_first
        assign w_cin_g = i_cin;
      end else begin : g_chain
        assign w_cin_g = g_grp[gi-1].w_cout_g;
      end

      always_comb begin
        w_gg    = '0;
        w_gp    = '0;
        w_sum_g = '0;
        w_gp[0] = 1'b1;
        for (int j = 0; j < GW; j++) begin
          w_gg[j+1]  = w_g[LO+j] | (w_p[LO+j] & w_gg[j]);
          w_gp[j+1]  = w_p[LO+j] & w_gp[j];
          w_sum_g[j] = w_p[LO+j] ^ (w_gg[j] | (w_gp[j] & w_cin_g));
        end
        w_cout_g = w_gg[GW] | (w_gp[GW] & w_cin_g);
      end

      assign o_sum[LO +: GW] = w_sum_g;
    end
  endgenerate

  assign o_cout = g_grp[NG-1].w_cout_g;
endmodule

module subtract_lookahead_pipe_16_bit #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sbc,
  input  logic             in_cy,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_z,
  output logic             out_s,
  output logic             out_cy,
  output logic             out_ov,
  output logic [TAG_W-1:0] out_tag
);
  localparam int HW = WIDTH / 2;

  // Stage 1 state
  logic             r_s1_valid;
  logic [HW-1:0]    r_s1_lo;
  logic             r_s1_c;
  logic [HW-1:0]    r_s1_a_hi;
  logic [HW-1:0]    r_s1_b_hi;
  logic [TAG_W-1:0] r_s1_tag;

  // Stage 2 (output) state
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_z;
  logic             r_s;
  logic             r_cy;
  logic             r_ov;
  logic [TAG_W-1:0] r_tag;

  logic             w_cin;
  logic [HW-1:0]    w_lo_sum;
  logic             w_lo_cout;
  logic [HW-1:0]    w_hi_sum;
  logic             w_hi_cout;
  logic             w_s2_adv;
  logic             w_accept;
  logic [WIDTH-1:0] w_full;

  // SUB/CMP feed a carry of 1 (no borrow). SBC feeds the live CY flag.
  assign w_cin = in_sbc ? in_cy : 1'b1;

  sub_la_half #(.HW(HW)) u_lo (
    .i_a    (in_a[HW-1:0]),
    .i_nb   (~in_b[HW-1:0]),
    .i_cin  (w_cin),
    .o_sum  (w_lo_sum),
    .o_cout (w_lo_cout)
  );

  sub_la_half #(.HW(HW)) u_hi (
    .i_a    (r_s1_a_hi),
    .i_nb   (~r_s1_b_hi),
    .i_cin  (r_s1_c),
    .o_sum  (w_hi_sum),
    .o_cout (w_hi_cout)
  );

  assign w_full = {w_hi_sum, r_s1_lo};

  // Stage 2 drains whenever it is empty or the consumer takes its result.
  // Stage 1 moves into stage 2 under the same condition. A full stage 1 can
  // therefore refill on the same edge that it hands its entry over.
  assign w_s2_adv = ~r_s2_valid | out_ready;
  assign in_ready = ~r_s1_valid | w_s2_adv;
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_lo    <= '0;
      r_s1_c     <= 1'b0;
      r_s1_a_hi  <= '0;
      r_s1_b_hi  <= '0;
      r_s1_tag   <= '0;
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_z        <= 1'b0;
      r_s        <= 1'b0;
      r_cy       <= 1'b0;
      r_ov       <= 1'b0;
      r_tag      <= '0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_result <= w_full;
          r_z      <= ~|w_full;
          r_s      <= w_hi_sum[HW-1];
          r_cy     <= w_hi_cout;
          // Overflow only when the operand signs differ and the result sign
          // differs from the minuend's sign.
          r_ov     <= (r_s1_a_hi[HW-1] ^ r_s1_b_hi[HW-1]) &
                      (r_s1_a_hi[HW-1] ^ w_hi_sum[HW-1]);
          r_tag    <= r_s1_tag;
        end
      end
      if (in_ready) begin
        r_s1_valid <= in_valid;
        if (w_accept) begin
          r_s1_lo   <= w_lo_sum;
          r_s1_c    <= w_lo_cout;
          r_s1_a_hi <= in_a[WIDTH-1:HW];
          r_s1_b_hi <= in_b[WIDTH-1:HW];
          r_s1_tag  <= in_tag;
        end
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_result;
  assign out_z      = r_z;
  assign out_s      = r_s;
  assign out_cy     = r_cy;
  assign out_ov     = r_ov;
  assign out_tag    = r_tag;
endmodule
